// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: steps ALU, unified memory and register file
// through fetch/decode/execute/memory/write-back, traps unknown opcodes, counts retirements.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StTrap   = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // Strobes before the reset gate; reset must silence them even mid-cycle.
  logic pc_write_s, pc_write_cond_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb:  state_d = StFetch;
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      StMemWb, StAluWb, StBranch, StJump, StAddiWb: retire = 1'b1;
      StMemWr:                                      retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  assign illegal_d = illegal_q | (state_d == StTrap);

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read_s = 1'b1;
        i_or_d     = 1'b1;
      end
      StMemWb: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      StMemWr: begin
        mem_write_s = 1'b1;
        i_or_d      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      StBranch: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source       = 2'b01;
      end
      StJump: begin
        pc_write_s = 1'b1;
        pc_source  = 2'b10;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: begin
        reg_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write      = pc_write_s & ~rst;
  assign pc_write_cond = pc_write_cond_s & ~rst;
  assign ir_write      = ir_write_s & ~rst;
  assign reg_write     = reg_write_s & ~rst;
  assign mem_read      = mem_read_s & ~rst;
  assign mem_write     = mem_write_s & ~rst;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench: each instruction is expanded into its expected
// per-cycle state walk and control word, with the retire count kept modulo 16.
module tb_multicycle_control;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      opcode;
  logic            mem_ready;
  logic            pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic            mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]      alu_src_b, alu_op, pc_source;
  logic [3:0]      state;
  logic            illegal;
  logic [CntW-1:0] retired;

  multicycle_control #(.CNT_W(CntW)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal       (illegal),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;

  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;
  logic [CntW-1:0] exp_ret;
  logic [16:0]     ctrl;
  logic [5:0]      strobes;

  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
  assign strobes = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, advance past the rising edge.
  task automatic step(input int st, input logic rdy, input logic [5:0] opc);
    mem_ready = rdy;
    opcode    = opc;
    @(negedge clk);
    check_eq($sformatf("state(exp %0d)", st), 32'(state), 32'(st));
    check_eq($sformatf("ctrl(st %0d rdy %0b)", st, rdy), 32'(ctrl), 32'(exp_ctrl(st, rdy)));
    check_eq("retired", 32'(retired), 32'(exp_ret));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(63, 0));
  endfunction

  // Full instruction: fw fetch stalls, mw memory stalls; unused inputs are randomised.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(0, 1'b0, rnd_op());
    step(0, 1'b1, rnd_op());
    step(1, rnd_bit(), op);
    case (op)
      OpR:    begin step(6, rnd_bit(), rnd_op()); step(7, rnd_bit(), rnd_op()); end
      OpLw: begin
        step(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(3, 1'b0, rnd_op());
        step(3, 1'b1, rnd_op());
        step(4, rnd_bit(), rnd_op());
      end
      OpSw: begin
        step(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(5, 1'b0, rnd_op());
        step(5, 1'b1, rnd_op());
      end
      OpBeq:  step(8, rnd_bit(), rnd_op());
      OpJ:    step(9, rnd_bit(), rnd_op());
      default: begin step(10, rnd_bit(), rnd_op()); step(11, rnd_bit(), rnd_op()); end
    endcase
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic reset_pulse();
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_strobes", 32'(strobes), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_strobes_held", 32'(strobes), 32'd0);
    rst = 1'b0;
    exp_ret = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    ops = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi};
    exp_ret   = '0;
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = '0;
    #2;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_strobes", 32'(strobes), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(OpR, 0, 0);
    run_instr(OpLw, 0, 2);
    run_instr(OpSw, 0, 0);
    run_instr(OpBeq, 0, 0);
    run_instr(OpAddi, 3, 0);
    for (int i = 0; i < 16; i++) run_instr(OpJ, 0, 0);
    for (int i = 0; i < 60; i++)
      run_instr(ops[$urandom_range(5, 0)], $urandom_range(2, 0), $urandom_range(2, 0));

    // Reset landing mid-cycle while MEMRD is stalled.
    step(0, 1'b1, rnd_op());
    step(1, 1'b0, OpLw);
    step(2, 1'b0, OpLw);
    step(3, 1'b0, rnd_op());
    mem_ready = 1'b0;
    #2;
    reset_pulse();

    run_instr(OpSw, 1, 1);
    step(0, 1'b1, rnd_op());
    step(1, 1'b1, 6'b111111);
    for (int i = 0; i < 10; i++) step(12, rnd_bit(), rnd_op());
    #2;
    reset_pulse();
    run_instr(OpBeq, 0, 0);
    step(0, 1'b0, rnd_op());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath; replaces the single-cycle CONTROL decode.
- One FSM steps the shared ALU, the unified memory, and the register file through FETCH/DECODE/EXECUTE/MEM/WB.
- Handles memory wait states, traps unsupported opcodes, and counts retired instructions.
- Sits beside the datapath and drives every mux select and write strobe.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-data select: 1=MDR, 0=ALUOut.
- reg_dst  out  1  write register select: 1=rd, 0=rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B select: 00=regB, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- alu_op  out  2  to ALUControl: 00=add, 01=sub, 10=funct.
- pc_source  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky trap flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Reset (async, any state, including mid-wait): state=FETCH, illegal=0, retired=0.
  - While rst=1, pc_write, pc_write_cond, ir_write, reg_write, mem_read and mem_write are forced to 0.
- Outputs are combinational from state; only FETCH strobes also depend on mem_ready. Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_write=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 000000→EXEC; 100011 or 101011→MEMADR; 000100→BRANCH; 000010→JUMP; 001000→ADDIEX; any other value→TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- TRAP: all strobes 0; illegal=1 and sticky; the FSM stays in TRAP until rst.
- retired increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, JUMP or ADDIWB, or leaving MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W. TRAP does not increment.
- Latency with mem_ready tied to 1, in cycles: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- opcode changes are only observed in DECODE and MEMADR.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 → state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. retired=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout MEMRD. retired=1 after 7 cycles.
- sw (101011) then beq (000100), mem_ready=1 → sw: 0,1,2,5,0 with mem_write=1 only in state 5. beq: 0,1,8,0 with pc_write_cond=1 and alu_op=01. retired=2.
- FETCH with mem_ready=0 for 3 cycles → state stays 0; ir_write=0 and pc_write=0 until the mem_ready=1 cycle, where both are 1 for exactly one cycle.
- opcode=111111 in DECODE → state 12, illegal=1. All strobes stay 0 for 10 cycles; retired is unchanged.
- rst pulsed while in MEMRD stalled, then in TRAP → state=0, illegal=0, retired=0 immediately (async). No strobes while rst=1.
- Run 2^CNT_W j instructions with CNT_W=4 → retired wraps from 15 to 0.
